// File: rtl/hdmi_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_pkg
// Shared types and default timing for the HDMI-style pattern source and for
// the codec benches that consume its stream.
//   h_state_t / v_state_t : horizontal / vertical phase of the raster
//   pattern_t             : test pattern selector
//   pixel_t               : one 8-bit Y/Cr/Cb component
//   DEF_*                 : default timing (2160x1200, 2 pixels per clock)
// -----------------------------------------------------------------------------
package hdmi_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {H_SYNC, H_BP, H_ACT, H_FP} h_state_t;
  typedef enum logic [1:0] {V_SYNC, V_BP, V_ACT, V_FP} v_state_t;
  typedef enum logic [1:0] {PAT_RAMP, PAT_CHECKER, PAT_VRAMP, PAT_FLAT} pattern_t;

  localparam int DEF_N                 = 2;
  localparam int DEF_X_RES             = 2160;
  localparam int DEF_Y_RES             = 1200;
  localparam int DEF_H_SYNC_CYC        = 20;
  localparam int DEF_H_BACK_PORCH_CYC  = 46;
  localparam int DEF_H_FRONT_PORCH_CYC = 40;
  localparam int DEF_V_SYNC_CYC        = 2;
  localparam int DEF_V_BACK_PORCH_CYC  = 24;
  localparam int DEF_V_FRONT_PORCH_CYC = 28;

  // Checkerboard levels are video-range black/white; chroma sits at neutral.
  localparam pixel_t CHECK_LO   = 8'd16;
  localparam pixel_t CHECK_HI   = 8'd235;
  localparam pixel_t CHROMA_MID = 8'd128;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/hdmi_pattern_lane.sv
// -----------------------------------------------------------------------------
// hdmi_pattern_lane
// Combinational pixel generator for one lane.
//   pattern   : latched pattern of the current frame
//   col       : low byte of the absolute column of this lane
//   row       : low byte of the active row
//   frame_cnt : frame counter shown by the flat pattern
//   y/cr/cb   : generated components
// -----------------------------------------------------------------------------
module hdmi_pattern_lane
  import hdmi_pkg::*;
(
  input  pattern_t   pattern,
  input  logic [7:0] col,
  input  logic [7:0] row,
  input  pixel_t     frame_cnt,
  output pixel_t     y,
  output pixel_t     cr,
  output pixel_t     cb
);

  always_comb begin
    // NOTE: defaults first, so no branch leaves an output unassigned (no latch).
    y  = '0;
    cr = '0;
    cb = '0;
    case (pattern)
      PAT_RAMP: begin
        y  = col;
        cr = col;
        cb = col;
      end
      PAT_CHECKER: begin
        // 8x8 tiles: bit 3 of column and row selects the tile parity.
        y  = (col[3] ^ row[3]) ? CHECK_HI : CHECK_LO;
        cr = CHROMA_MID;
        cb = CHROMA_MID;
      end
      PAT_VRAMP: begin
        y  = row;
        cr = row;
        cb = row;
      end
      PAT_FLAT: begin
        y  = frame_cnt;
        cr = frame_cnt;
        cb = frame_cnt;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hdmi_pattern_gen.sv
// -----------------------------------------------------------------------------
// hdmi_pattern_gen
// Frame-accurate HDMI-style video source, N pixels per clock.
//   clk, rst_n           : clock, asynchronous active-low reset
//   en                   : run enable, acted on only at frame boundaries
//   i_pattern_sel        : pattern select, latched when a frame begins
//   o_hdmi_v_sync        : high for whole V_SYNC lines
//   o_hdmi_h_sync        : high during H_SYNC of every line
//   o_hdmi_data_valid    : active pixel cycle (H_ACT and V_ACT)
//   o_hdmi_data_y/cr/cb  : per-lane components, zero when not valid
//   o_frame_start        : pulse on the first h_sync cycle of a frame
// All outputs are registered from the raster state, so they trail the
// state registers by one clock.
// -----------------------------------------------------------------------------
module hdmi_pattern_gen
  import hdmi_pkg::*;
#(
  parameter int N                 = DEF_N,
  parameter int X_RES             = DEF_X_RES,
  parameter int Y_RES             = DEF_Y_RES,
  parameter int H_SYNC_CYC        = DEF_H_SYNC_CYC,
  parameter int H_BACK_PORCH_CYC  = DEF_H_BACK_PORCH_CYC,
  parameter int H_FRONT_PORCH_CYC = DEF_H_FRONT_PORCH_CYC,
  parameter int V_SYNC_CYC        = DEF_V_SYNC_CYC,
  parameter int V_BACK_PORCH_CYC  = DEF_V_BACK_PORCH_CYC,
  parameter int V_FRONT_PORCH_CYC = DEF_V_FRONT_PORCH_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       i_pattern_sel,
  output logic             o_hdmi_v_sync,
  output logic             o_hdmi_h_sync,
  output logic             o_hdmi_data_valid,
  output logic [N-1:0][7:0] o_hdmi_data_y,
  output logic [N-1:0][7:0] o_hdmi_data_cr,
  output logic [N-1:0][7:0] o_hdmi_data_cb,
  output logic             o_frame_start
);

  localparam int H_ACT_CYC = X_RES / N;
  localparam int H_MAX = max4(H_SYNC_CYC, H_BACK_PORCH_CYC, H_ACT_CYC, H_FRONT_PORCH_CYC);
  localparam int V_MAX = max4(V_SYNC_CYC, V_BACK_PORCH_CYC, Y_RES, V_FRONT_PORCH_CYC);
  localparam int HW = (H_MAX > 1) ? $clog2(H_MAX) : 1;
  localparam int VW = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if (N < 1 || X_RES % (8 * N) != 0) begin : g_bad_x_res
    $error("hdmi_pattern_gen: X_RES must be a nonzero multiple of 8*N");
  end
  if (Y_RES % 8 != 0) begin : g_bad_y_res
    $error("hdmi_pattern_gen: Y_RES must be a multiple of 8");
  end
  if (H_SYNC_CYC < 1 || H_BACK_PORCH_CYC < 1 || H_FRONT_PORCH_CYC < 1 || H_ACT_CYC < 1 ||
      V_SYNC_CYC < 1 || V_BACK_PORCH_CYC < 1 || V_FRONT_PORCH_CYC < 1 || Y_RES < 1)
  begin : g_zero_phase
    $error("hdmi_pattern_gen: every sync, porch and active phase must be nonzero");
  end

  function automatic logic [HW-1:0] h_last_cnt(input h_state_t s);
    case (s)
      H_SYNC:  return HW'(H_SYNC_CYC - 1);
      H_BP:    return HW'(H_BACK_PORCH_CYC - 1);
      H_ACT:   return HW'(H_ACT_CYC - 1);
      default: return HW'(H_FRONT_PORCH_CYC - 1);
    endcase
  endfunction

  function automatic logic [VW-1:0] v_last_cnt(input v_state_t s);
    case (s)
      V_SYNC:  return VW'(V_SYNC_CYC - 1);
      V_BP:    return VW'(V_BACK_PORCH_CYC - 1);
      V_ACT:   return VW'(Y_RES - 1);
      default: return VW'(V_FRONT_PORCH_CYC - 1);
    endcase
  endfunction

  function automatic h_state_t h_next(input h_state_t s);
    case (s)
      H_SYNC:  return H_BP;
      H_BP:    return H_ACT;
      H_ACT:   return H_FP;
      default: return H_SYNC;
    endcase
  endfunction

  function automatic v_state_t v_next(input v_state_t s);
    case (s)
      V_SYNC:  return V_BP;
      V_BP:    return V_ACT;
      V_ACT:   return V_FP;
      default: return V_SYNC;
    endcase
  endfunction

  logic [0:0]  state;
  h_state_t    h_state;
  v_state_t    v_state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  pattern_t    pattern;
  pixel_t      frame_cnt;
  logic        first_frame_done;

  logic h_last, v_last, line_end, frame_end, frame_begin;
  logic run, valid_d;

  always_comb begin
    h_last      = (h_cnt == h_last_cnt(h_state));
    v_last      = (v_cnt == v_last_cnt(v_state));
    line_end    = h_last && (h_state == H_FP);
    frame_end   = line_end && v_last && (v_state == V_FP);
    // IDLE holds the raster at H_SYNC/V_SYNC, so only the state matters there.
    frame_begin = en && ((state == ST_IDLE) || frame_end);
    run         = (state == ST_RUN);
    valid_d     = run && (h_state == H_ACT) && (v_state == V_ACT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      h_state          <= H_SYNC;
      v_state          <= V_SYNC;
      h_cnt            <= '0;
      v_cnt            <= '0;
      pattern          <= PAT_RAMP;
      frame_cnt        <= '0;
      first_frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (state == ST_RUN) begin
        // The raster wraps to H_SYNC/V_SYNC on its own at frame end, which is
        // exactly the parking position IDLE expects.
        if (h_last) begin
          h_cnt   <= '0;
          h_state <= h_next(h_state);
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
        if (line_end) begin
          if (v_last) begin
            v_cnt   <= '0;
            v_state <= v_next(v_state);
          end else begin
            v_cnt <= v_cnt + 1'b1;
          end
        end
        if (frame_end && !en) state <= ST_IDLE;
      end else if (en) begin
        state <= ST_RUN;
      end

      if (frame_begin) begin
        pattern          <= pattern_t'(i_pattern_sel);
        first_frame_done <= 1'b1;
        if (first_frame_done) frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  logic [N-1:0][7:0] lane_y, lane_cr, lane_cb;

  for (genvar k = 0; k < N; k++) begin : g_lane
    hdmi_pattern_lane u_lane (
      .pattern   (pattern),
      .col       (8'(N * int'(h_cnt) + k)),
      .row       (8'(v_cnt)),
      .frame_cnt (frame_cnt),
      .y         (lane_y[k]),
      .cr        (lane_cr[k]),
      .cb        (lane_cb[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_hdmi_v_sync     <= 1'b0;
      o_hdmi_h_sync     <= 1'b0;
      o_hdmi_data_valid <= 1'b0;
      o_hdmi_data_y     <= '0;
      o_hdmi_data_cr    <= '0;
      o_hdmi_data_cb    <= '0;
      o_frame_start     <= 1'b0;
    end else begin
      o_hdmi_v_sync     <= run && (v_state == V_SYNC);
      o_hdmi_h_sync     <= run && (h_state == H_SYNC);
      o_hdmi_data_valid <= valid_d;
      o_hdmi_data_y     <= valid_d ? lane_y  : '0;
      o_hdmi_data_cr    <= valid_d ? lane_cr : '0;
      o_hdmi_data_cb    <= valid_d ? lane_cb : '0;
      o_frame_start     <= run && (h_state == H_SYNC) && (h_cnt == '0) &&
                           (v_state == V_SYNC) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_hdmi_pattern_gen
// Small raster (16x16, 2 lanes, every sync/porch 2) so whole frames are cheap.
// The reference model derives every output from the cycle offset within a
// frame using line/column arithmetic and the pattern rules.
// -----------------------------------------------------------------------------
module tb_hdmi_pattern_gen;

  localparam int N      = 2;
  localparam int X_RES  = 16;
  localparam int Y_RES  = 16;
  localparam int HS     = 2;
  localparam int HBP    = 2;
  localparam int HFP    = 2;
  localparam int VS     = 2;
  localparam int VBP    = 2;
  localparam int VFP    = 2;

  localparam int LINE_CYC  = HS + HBP + X_RES / N + HFP;
  localparam int FRAME_LN  = VS + VBP + Y_RES + VFP;
  localparam int FRAME_CYC = LINE_CYC * FRAME_LN;
  localparam int H_OFF     = HS + HBP;
  localparam int V_OFF     = VS + VBP;
  localparam int OW        = 4 + 3 * 8 * N;

  localparam int ACT_NONE    = 0;
  localparam int ACT_SWITCH  = 1;
  localparam int ACT_DROP_EN = 2;
  localparam int ACT_RESET   = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [1:0] i_pattern_sel;
  logic o_hdmi_v_sync, o_hdmi_h_sync, o_hdmi_data_valid, o_frame_start;
  logic [N-1:0][7:0] o_hdmi_data_y, o_hdmi_data_cr, o_hdmi_data_cb;

  int checks = 0;
  int errors = 0;
  int frames_seen = 0;
  int cur_pat = 0;

  always #5 clk = ~clk;

  hdmi_pattern_gen #(
    .N(N), .X_RES(X_RES), .Y_RES(Y_RES),
    .H_SYNC_CYC(HS), .H_BACK_PORCH_CYC(HBP), .H_FRONT_PORCH_CYC(HFP),
    .V_SYNC_CYC(VS), .V_BACK_PORCH_CYC(VBP), .V_FRONT_PORCH_CYC(VFP)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .en                (en),
    .i_pattern_sel     (i_pattern_sel),
    .o_hdmi_v_sync     (o_hdmi_v_sync),
    .o_hdmi_h_sync     (o_hdmi_h_sync),
    .o_hdmi_data_valid (o_hdmi_data_valid),
    .o_hdmi_data_y     (o_hdmi_data_y),
    .o_hdmi_data_cr    (o_hdmi_data_cr),
    .o_hdmi_data_cb    (o_hdmi_data_cb),
    .o_frame_start     (o_frame_start)
  );

  function automatic logic [OW-1:0] observed();
    return {o_frame_start, o_hdmi_v_sync, o_hdmi_h_sync, o_hdmi_data_valid,
            o_hdmi_data_y, o_hdmi_data_cr, o_hdmi_data_cb};
  endfunction

  // Expected outputs at cycle t of a frame (t = 0 is the o_frame_start cycle).
  function automatic logic [OW-1:0] model(input int t, input int pat, input int flat);
    int line, x, col, row, c, pv;
    logic val;
    logic [8*N-1:0] y, cr, cb;
    line = t / LINE_CYC;
    x    = t % LINE_CYC;
    y = '0; cr = '0; cb = '0;
    val = (x >= H_OFF) && (x < H_OFF + X_RES / N) && (line >= V_OFF) && (line < V_OFF + Y_RES);
    if (val) begin
      col = x - H_OFF;
      row = line - V_OFF;
      for (int k = 0; k < N; k++) begin
        c = N * col + k;
        case (pat)
          0: begin pv = c % 256; y[k*8 +: 8] = 8'(pv); cr[k*8 +: 8] = 8'(pv); cb[k*8 +: 8] = 8'(pv); end
          1: begin
            pv = (((c / 8) % 2) != ((row / 8) % 2)) ? 235 : 16;
            y[k*8 +: 8] = 8'(pv); cr[k*8 +: 8] = 8'd128; cb[k*8 +: 8] = 8'd128;
          end
          2: begin pv = row % 256; y[k*8 +: 8] = 8'(pv); cr[k*8 +: 8] = 8'(pv); cb[k*8 +: 8] = 8'(pv); end
          default: begin y[k*8 +: 8] = 8'(flat); cr[k*8 +: 8] = 8'(flat); cb[k*8 +: 8] = 8'(flat); end
        endcase
      end
    end
    return {t == 0, line < VS, x < HS, val, y, cr, cb};
  endfunction

  function automatic int rand_active_t();
    return (V_OFF + int'($urandom_range(0, Y_RES - 1))) * LINE_CYC
           + H_OFF + int'($urandom_range(0, X_RES / N - 1));
  endfunction

  // Wait (bounded) for the next frame start, then compare every cycle of the
  // frame; optionally perform one action at cycle act_t.
  task automatic run_frame(input string name, input int exp_pat, input int budget,
                           input int act_kind, input int act_t, input int act_val);
    int found;
    int flat;
    logic [OW-1:0] exp_v, obs_v;
    found = 0;
    @(negedge clk);
    for (int i = 0; i < budget; i++) begin
      if (o_frame_start === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL %s frame_start: not seen within %0d cycles, expected by then", name, budget);
      return;
    end
    frames_seen++;
    flat = (frames_seen - 1) % 256;
    for (int t = 0; t < FRAME_CYC; t++) begin
      if (t > 0) @(negedge clk);
      exp_v = model(t, exp_pat, flat);
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL %s t=%0d actual=%h expected=%h", name, t, obs_v, exp_v);
      end
      if (t == act_t) begin
        case (act_kind)
          ACT_SWITCH:  i_pattern_sel = 2'(act_val);
          ACT_DROP_EN: en = 1'b0;
          ACT_RESET: begin
            #2 rst_n = 1'b0;
            #1;
            checks++;
            if (observed() !== '0) begin
              errors++;
              $display("FAIL %s async_reset t=%0d actual=%h expected=0", name, t, observed());
            end
            return;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    i_pattern_sel = 2'd0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (observed() !== '0) begin
        errors++;
        $display("FAIL reset_state actual=%h expected=0", observed());
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL first_edge_after_release actual=%h expected=0", observed());
    end
    frames_seen = 0;
  endtask

  // First frame must stay ramp; the frame after the mid-frame switch is vramp.
  task automatic test_pattern_switch();
    run_frame("ramp_switch", 0, 1, ACT_SWITCH, rand_active_t(), 2);
    run_frame("vramp", 2, 1, ACT_NONE, -1, 0);
    cur_pat = 2;
  endtask

  task automatic test_back_to_back();
    int nxt;
    repeat (3) begin
      nxt = int'($urandom_range(0, 3));
      run_frame("back_to_back", cur_pat, 1, ACT_SWITCH, rand_active_t(), nxt);
      cur_pat = nxt;
    end
  endtask

  task automatic test_en_drop();
    run_frame("en_drop", cur_pat, 1, ACT_DROP_EN, rand_active_t(), 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (observed() !== '0) begin
        errors++;
        $display("FAIL idle_after_drop cyc=%0d actual=%h expected=0", i, observed());
      end
    end
    cur_pat = int'($urandom_range(0, 3));
    i_pattern_sel = 2'(cur_pat);
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL restart_latency actual=%h expected=0", observed());
    end
    run_frame("restart", cur_pat, 1, ACT_NONE, -1, 0);
  endtask

  task automatic test_reset_mid_line();
    run_frame("reset_mid_line", cur_pat, 1, ACT_RESET, rand_active_t(), 0);
    @(negedge clk);
    checks++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL held_in_reset actual=%h expected=0", observed());
    end
    frames_seen = 0;
    i_pattern_sel = 2'd3;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL post_reset_first_edge actual=%h expected=0", observed());
    end
  endtask

  // Flat value must run 0..255 and wrap to 0 on the 257th frame.
  task automatic test_flat_wrap();
    for (int f = 0; f < 257; f++) begin
      run_frame("flat_wrap", 3, 1, ACT_NONE, -1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_pattern_switch();
    test_back_to_back();
    test_en_drop();
    test_reset_mid_line();
    test_flat_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdmi_pattern_gen.md
# hdmi_pattern_gen

Synthesizable HDMI-style video source for the JPEG codec datapath. It produces the sync/valid/pixel stream consumed directly by `codec`'s `i_hdmi_*` inputs: N pixels per clock, 8-bit Y/Cr/Cb per lane, with programmable sync and porch timing. It drives on-board self-test and replaces ad-hoc bench stimulus with a repeatable, frame-accurate source.

## Interface
- `N`, 2: pixels per clock (lanes).
- `X_RES`, 2160: active pixels per line; must be a multiple of 8*N.
- `Y_RES`, 1200: active lines per frame; must be a multiple of 8.
- `H_SYNC_CYC`, 20: h_sync width, in clocks.
- `H_BACK_PORCH_CYC`, 46: clocks from h_sync falling to the first valid.
- `H_FRONT_PORCH_CYC`, 40: clocks after the last valid.
- `V_SYNC_CYC`, 2: lines with v_sync high.
- `V_BACK_PORCH_CYC`, 24: blank lines after v_sync.
- `V_FRONT_PORCH_CYC`, 28: blank lines after active lines.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `en`  in  1: run enable, sampled at frame boundary.
- `i_pattern_sel`  in  2: pattern select, sampled at frame start.
- `o_hdmi_v_sync`  out  1: vertical sync.
- `o_hdmi_h_sync`  out  1: horizontal sync.
- `o_hdmi_data_valid`  out  1: active pixel cycle.
- `o_hdmi_data_y`  out  [N-1:0][7:0]: luma per lane.
- `o_hdmi_data_cr`  out  [N-1:0][7:0]: Cr per lane.
- `o_hdmi_data_cb`  out  [N-1:0][7:0]: Cb per lane.
- `o_frame_start`  out  1: one-cycle pulse on the first h_sync cycle of each frame.

## Operation
- Horizontal FSM `H_SYNC → H_BP → H_ACT → H_FP → H_SYNC`. Phase lengths are H_SYNC_CYC, H_BACK_PORCH_CYC, X_RES/N, H_FRONT_PORCH_CYC. Line length L = 1186 at defaults.
- Vertical FSM advances on the last H_FP cycle: `V_SYNC → V_BP → V_ACT → V_FP`. Phase lengths are V_SYNC_CYC, V_BACK_PORCH_CYC, Y_RES, V_FRONT_PORCH_CYC lines. Frame length is 1254 lines.
- Top FSM `IDLE / RUN`:
  - `IDLE`: all outputs are 0. On `en`=1, the next cycle begins the frame at `V_SYNC`/`H_SYNC`.
  - At the end of the last V_FP line, continue to a new frame if `en`=1, else go to `IDLE`.
  - `en` falling mid-frame never truncates the frame.
- `o_hdmi_h_sync` is high in `H_SYNC` on every line, including blank lines. `o_hdmi_v_sync` is high for entire V_SYNC lines.
- `o_hdmi_data_valid` is high only when H_ACT and V_ACT are both true.
- Pattern is latched at frame start. Column of lane k is c = N*col_cnt + k; r is the active row.
  - 0 ramp: Y = Cr = Cb = c[7:0].
  - 1 checker 8x8: Y = (c[3]^r[3]) ? 235 : 16; Cr = Cb = 128.
  - 2 vertical ramp: Y = Cr = Cb = r[7:0].
  - 3 flat: Y = Cr = Cb = frame_cnt[7:0]. frame_cnt is 8-bit, wraps 255→0, and increments at each frame start after the first.
- Pixel data is 0 whenever valid is 0.

## Timing
- All outputs are registered. Reset value of every output is 0, the FSMs are in `IDLE`, and frame_cnt is 0.
- With `en` high across reset release, the first cycle with `o_hdmi_h_sync` = `o_hdmi_v_sync` = `o_frame_start` = 1 is the second rising edge after `rst_n` rises.
- Within a line:
  - first valid occurs H_SYNC_CYC + H_BACK_PORCH_CYC cycles after h_sync rises;
  - valid stays high for exactly X_RES/N consecutive cycles;
  - valid never overlaps sync.
- Pixel data is coincident with valid; there is no extra latency.
- `i_pattern_sel` changes mid-frame have no effect until the next `o_frame_start`.
- Reset asserted mid-line forces all outputs to 0 asynchronously. After release, generation restarts at a frame start; no partial line is emitted.
- Counters are sized with `$clog2` of the maximum phase length. Elaboration fails on an X_RES/Y_RES divisibility violation or any zero-length phase.

## Structure
- Shared package `hdmi_pkg`:
  - `h_state_t`, `v_state_t`, `pattern_t` enums;
  - default porch/sync constants, also reused by codec benches;
  - `pixel_t` (`[7:0]`).
- One sub-module, `hdmi_pattern_lane`. It is combinational: it maps (pattern, c, r, frame_cnt) to Y/Cr/Cb for one lane and is instantiated N times via generate. The top owns the FSMs, counters and output registers.

## Test plan
- Defaults, pattern 0, `en`=1:
  - h_sync period is 1186 cycles, high for 20;
  - first valid 66 cycles after h_sync rises, 1080 valid cycles per line;
  - 1,296,000 valid cycles per frame;
  - frame period 1,487,244 cycles;
  - lane 0 of the first two valid cycles = 0, 2; lane 1 = 1, 3.
- Small config X_RES=16, Y_RES=16, N=2, all porches 2, pattern 1:
  - row 0: Y = 16 ×8 then 235 ×8;
  - row 8: inverted;
  - Cr = Cb = 128 throughout.
- Pattern 3 over 257 frames (small config): flat value runs 0, 1, …, 255, 0.
- `en` dropped in V_ACT mid-line: frame completes, outputs go to 0 after the last V_FP line, no `o_frame_start`. Re-raising `en` starts a fresh frame.
- `rst_n` pulsed mid-H_ACT: all outputs are 0 during reset; the next activity is a full `o_frame_start` line with v_sync and h_sync high.
- Pattern switch 0→2 mid-frame: current frame stays ramp. The next frame's row 5 shows Y = 5 in all lanes.
